// File: rtl/mem_stage_vector_seq.sv
// ============================================================================
// Module   : mem_stage_vector_seq
// Function : Memory stage of the vector ASIP pipeline. Scalar and vector
//            loads and stores go through one synchronous-read data-memory
//            port, one lane per cycle. Optional macro MEM_BOUNDS_CHECK_EN
//            suppresses out-of-range accesses and flags them on addr_err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_vector_seq #(
    parameter int N      = 32,
    parameter int V      = 20,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_i,
    input  logic              MemWE_i,
    input  logic              WBSelect_i,
    input  logic              OpSource_i,
    input  logic [N-1:0]      AluResult_S_i,
    input  logic [N-1:0]      RD2_S_i,
    input  logic [V*N-1:0]    RD2_V_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [N-1:0]      mem_wdata_o,
    output logic              mem_we_o,
    input  logic [N-1:0]      mem_rdata_i,
    output logic [N-1:0]      ReadData_S_o,
    output logic [V*N-1:0]    ReadData_V_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              addr_err_o
);

    localparam int CNT_W = (V > 1) ? $clog2(V) : 1;
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(V - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STORE = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base;
    logic              is_vec;
    logic              err;
    logic [N-1:0]      rd_s;
    logic [N-1:0]      rd_v     [V];
    logic [N-1:0]      st_lane  [V];

    logic              start_st;
    logic              start_ld;
    logic [CNT_W-1:0]  last;
    logic              cnt_last;
    logic              viol;
    logic              cap_en;
    logic [CNT_W-1:0]  cap_idx;
    logic [N-1:0]      cap_data;

    genvar g;
    generate
        for (g = 0; g < V; g++) begin : g_lanes
            assign st_lane[g]             = RD2_V_i[g*N +: N];
            assign ReadData_V_o[g*N +: N] = rd_v[g];
        end
    endgenerate

    // Store takes priority when both MemWE_i and WBSelect_i are set.
    assign start_st = valid_i & MemWE_i;
    assign start_ld = valid_i & ~MemWE_i & WBSelect_i;
    assign last     = is_vec ? LAST_V : '0;
    assign cnt_last = (cnt == last);

`ifdef MEM_BOUNDS_CHECK_EN
    logic [ADDR_W:0] span_end;
    assign span_end = {1'b0, AluResult_S_i[ADDR_W-1:0]}
                    + (OpSource_i ? (ADDR_W+1)'(V - 1) : '0);
    assign viol     = span_end[ADDR_W];
`else
    assign viol     = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, AluResult_S_i[N-1:ADDR_W]};

    always_comb begin
        state_nx    = state;
        ready_o     = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_addr_o  = base;
        case (state)
            S_IDLE: begin
                ready_o = valid_i & ~MemWE_i & ~WBSelect_i;
                if (start_st)
                    state_nx = S_STORE;
                else if (start_ld)
                    state_nx = S_LOAD;
            end
            S_STORE: begin
                mem_we_o    = ~err;
                mem_addr_o  = base + ADDR_W'(cnt);
                mem_wdata_o = is_vec ? st_lane[cnt] : RD2_S_i;
                if (cnt_last) begin
                    ready_o  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_LOAD: begin
                mem_addr_o = base + ADDR_W'(cnt);
                if (cnt_last)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: state_nx = S_DONE;
            S_DONE: begin
                ready_o  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so LOAD captures lane cnt-1
    // and DRAIN picks up the final lane.
    always_comb begin
        cap_en   = 1'b0;
        cap_idx  = '0;
        cap_data = err ? '0 : mem_rdata_i;
        if (state == S_LOAD && cnt != '0) begin
            cap_en  = 1'b1;
            cap_idx = cnt - CNT_W'(1);
        end else if (state == S_DRAIN) begin
            cap_en  = 1'b1;
            cap_idx = last;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            base   <= '0;
            is_vec <= 1'b0;
            err    <= 1'b0;
            rd_s   <= '0;
            for (int i = 0; i < V; i++)
                rd_v[i] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start_st | start_ld) begin
                        base   <= AluResult_S_i[ADDR_W-1:0];
                        is_vec <= OpSource_i;
                        err    <= viol;
                        cnt    <= '0;
                    end
                end
                S_STORE, S_LOAD: cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
                default: ;
            endcase
            if (cap_en) begin
                if (is_vec)
                    rd_v[cap_idx] <= cap_data;
                else
                    rd_s <= cap_data;
            end
        end
    end

    assign ReadData_S_o = rd_s;
    assign busy_o       = (state != S_IDLE);
    assign addr_err_o   = err & ready_o & busy_o;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_vector_seq.sv
// ============================================================================
// Module   : tb_mem_stage_vector_seq
// Function : Directed self-checking bench for mem_stage_vector_seq with a
//            behavioural synchronous-read data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_vector_seq;

    localparam int N      = 32;
    localparam int V      = 20;
    localparam int ADDR_W = 8;

    logic              CLK;
    logic              RST;
    logic              valid_i;
    logic              MemWE_i;
    logic              WBSelect_i;
    logic              OpSource_i;
    logic [N-1:0]      AluResult_S_i;
    logic [N-1:0]      RD2_S_i;
    logic [V*N-1:0]    RD2_V_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [N-1:0]      mem_wdata_o;
    logic              mem_we_o;
    logic [N-1:0]      mem_rdata_i;
    logic [N-1:0]      ReadData_S_o;
    logic [V*N-1:0]    ReadData_V_o;
    logic              ready_o;
    logic              busy_o;
    logic              addr_err_o;

    mem_stage_vector_seq #(.N(N), .V(V), .ADDR_W(ADDR_W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .valid_i       (valid_i),
        .MemWE_i       (MemWE_i),
        .WBSelect_i    (WBSelect_i),
        .OpSource_i    (OpSource_i),
        .AluResult_S_i (AluResult_S_i),
        .RD2_S_i       (RD2_S_i),
        .RD2_V_i       (RD2_V_i),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_we_o      (mem_we_o),
        .mem_rdata_i   (mem_rdata_i),
        .ReadData_S_o  (ReadData_S_o),
        .ReadData_V_o  (ReadData_V_o),
        .ready_o       (ready_o),
        .busy_o        (busy_o),
        .addr_err_o    (addr_err_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [N-1:0] mem [256];
    always @(posedge CLK) begin
        if (mem_we_o)
            mem[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= mem[mem_addr_o];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int         rdy_cyc;
    int         busy_cnt;
    logic       busy0;
    logic       err_rdy;
    logic [7:0] wr_q [$];

    // Presents one instruction at cycle 0 and holds it until ready_o.
    task automatic run_op(input logic we, input logic wb, input logic vec, input logic [7:0] b);
        @(posedge CLK); #1;
        valid_i = 1'b1; MemWE_i = we; WBSelect_i = wb; OpSource_i = vec;
        AluResult_S_i = {24'h0, b};
        rdy_cyc = -1; busy_cnt = 0; busy0 = 1'b0; err_rdy = 1'b0;
        wr_q.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (mem_we_o) wr_q.push_back(mem_addr_o);
            if (busy_o) busy_cnt++;
            if (c == 0) busy0 = busy_o;
            if (ready_o) begin
                rdy_cyc = c;
                err_rdy = addr_err_o;
            end
            @(posedge CLK); #1;
            if (rdy_cyc >= 0) break;
        end
        valid_i = 1'b0; MemWE_i = 1'b0; WBSelect_i = 1'b0; OpSource_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        RST = 1'b0; valid_i = 1'b0; MemWE_i = 1'b0; WBSelect_i = 1'b0;
        OpSource_i = 1'b0; AluResult_S_i = '0; RD2_S_i = '0; RD2_V_i = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", {31'b0, ready_o}, 32'd0);
        check("rst_busy",  {31'b0, busy_o},  32'd0);
        check("rst_we",    {31'b0, mem_we_o}, 32'd0);
        check("rst_addr",  {24'b0, mem_addr_o}, 32'd0);
        check("rst_rds",   ReadData_S_o, 32'd0);
        check("rst_err",   {31'b0, addr_err_o}, 32'd0);
        @(posedge CLK); #1 RST = 1'b1;

        // Scalar store
        RD2_S_i = 32'hDEADBEEF;
        run_op(1'b1, 1'b0, 1'b0, 8'h10);
        check("ss_ready_cyc", rdy_cyc, 32'd1);
        check("ss_nwr", wr_q.size(), 32'd1);
        if (wr_q.size() > 0) check("ss_addr", {24'b0, wr_q[0]}, 32'h10);
        check("ss_mem", mem[8'h10], 32'hDEADBEEF);

        // Scalar load
        run_op(1'b0, 1'b1, 1'b0, 8'h10);
        check("sl_ready_cyc", rdy_cyc, 32'd3);
        check("sl_nwr", wr_q.size(), 32'd0);
        check("sl_data", ReadData_S_o, 32'hDEADBEEF);
        check("sl_v_unch", ReadData_V_o[1*N +: N], 32'd0);

        // Vector store
        for (int i = 0; i < V; i++) RD2_V_i[i*N +: N] = 32'(2 * i);
        run_op(1'b1, 1'b0, 1'b1, 8'h20);
        check("vs_ready_cyc", rdy_cyc, 32'd20);
        check("vs_nwr", wr_q.size(), 32'd20);
        check("vs_busy_cnt", busy_cnt, 32'd20);
        check("vs_busy0", {31'b0, busy0}, 32'd0);
        if (wr_q.size() == 20) begin
            check("vs_addr_first", {24'b0, wr_q[0]}, 32'h20);
            check("vs_addr_last",  {24'b0, wr_q[19]}, 32'h33);
        end
        check("vs_mem_0x2a", mem[8'h2A], 32'd20);

        // Vector load
        RD2_V_i = '0;
        run_op(1'b0, 1'b1, 1'b1, 8'h20);
        check("vl_ready_cyc", rdy_cyc, 32'd22);
        check("vl_nwr", wr_q.size(), 32'd0);
        for (int i = 0; i < V; i++)
            check($sformatf("vl_lane%0d", i), ReadData_V_o[i*N +: N], 32'(2 * i));
        check("vl_s_unch", ReadData_S_o, 32'hDEADBEEF);

        // Scalar load after vector load leaves lanes alone
        run_op(1'b0, 1'b1, 1'b0, 8'h25);
        check("sl2_data", ReadData_S_o, 32'd10);
        check("sl2_v_unch", ReadData_V_o[5*N +: N], 32'd10);

        // Store wins over load
        RD2_S_i = 32'h12345678;
        run_op(1'b1, 1'b1, 1'b0, 8'h40);
        check("both_ready_cyc", rdy_cyc, 32'd1);
        check("both_mem", mem[8'h40], 32'h12345678);

        // Non-memory instruction
        run_op(1'b0, 1'b0, 1'b0, 8'h55);
        check("nm_ready_cyc", rdy_cyc, 32'd0);
        check("nm_nwr", wr_q.size(), 32'd0);
        check("nm_busy", busy_cnt, 32'd0);
        @(negedge CLK);
        check("nm_idle", {31'b0, busy_o}, 32'd0);

        // Reset during cycle 7 of a vector store
        for (int i = 0; i < V; i++) RD2_V_i[i*N +: N] = 32'h100 + 32'(i);
        @(posedge CLK); #1;
        valid_i = 1'b1; MemWE_i = 1'b1; OpSource_i = 1'b1; AluResult_S_i = 32'h20;
        repeat (7) @(posedge CLK);
        #1 RST = 1'b0;
        valid_i = 1'b0; MemWE_i = 1'b0; OpSource_i = 1'b0;
        #1;
        check("rm_we", {31'b0, mem_we_o}, 32'd0);
        check("rm_ready", {31'b0, ready_o}, 32'd0);
        check("rm_busy", {31'b0, busy_o}, 32'd0);
        check("rm_rdv", ReadData_V_o[3*N +: N], 32'd0);
        check("rm_rds", ReadData_S_o, 32'd0);
        @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK);
        check("rm_idle", {31'b0, busy_o}, 32'd0);
        check("rm_mem_0x20", mem[8'h20], 32'h100);
        check("rm_mem_0x25", mem[8'h25], 32'h105);
        check("rm_mem_0x26", mem[8'h26], 32'd12);

        // Vector store crossing the top of the address space
        for (int i = 0; i < V; i++) RD2_V_i[i*N +: N] = 32'h300 + 32'(i);
        run_op(1'b1, 1'b0, 1'b1, 8'hF0);
        check("wr_ready_cyc", rdy_cyc, 32'd20);
`ifdef MEM_BOUNDS_CHECK_EN
        check("wr_nwr", wr_q.size(), 32'd0);
        check("wr_err", {31'b0, err_rdy}, 32'd1);
        check("wr_mem_0xff", mem[8'hFF], 32'd0);
`else
        check("wr_nwr", wr_q.size(), 32'd20);
        check("wr_err", {31'b0, err_rdy}, 32'd0);
        check("wr_mem_0xff", mem[8'hFF], 32'h30F);
        check("wr_mem_0x03", mem[8'h03], 32'h313);
        if (wr_q.size() == 20)
            check("wr_addr_16", {24'b0, wr_q[16]}, 32'h00);
`endif
        @(negedge CLK);
        check("wr_err_after", {31'b0, addr_err_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
